// File: rtl/cache_miss_ctrl.sv
// Cache miss controller for a 2-way cache with 5-bit addresses and 8-bit data.
// Reads that hit return cache data; read misses fetch from memory and fill the
// cache; writes allocate into the cache and then write through to memory.
// Hit and miss counters saturate at 255.
module cache_miss_ctrl (
    input  logic       i_clock,
    input  logic       i_resetn,
    // CPU side
    input  logic       i_cpu_req,
    input  logic       i_cpu_we,
    input  logic [4:0] i_cpu_addr,
    input  logic [7:0] i_cpu_wdata,
    output logic       o_cpu_ready,
    output logic       o_cpu_done,
    output logic [7:0] o_cpu_rdata,
    // Cache side
    output logic [4:0] o_cache_addr,
    output logic       o_cache_wren,
    output logic [7:0] o_cache_wdata,
    input  logic       i_cache_hit,
    input  logic [7:0] i_cache_rdata,
    // Memory side
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic [4:0] o_mem_addr,
    output logic [7:0] o_mem_wdata,
    input  logic       i_mem_ack,
    input  logic [7:0] i_mem_rdata,
    // Statistics
    output logic [7:0] o_hit_count,
    output logic [7:0] o_miss_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCheck,
        StMemRd,
        StFill,
        StMemWr,
        StResp
    } state_e;

    localparam logic [7:0] CountMax = 8'hFF;

    state_e     r_state;
    state_e     w_state_next;

    // Request latched at acceptance; stays valid through the whole transaction.
    logic       r_we;
    logic [4:0] r_addr;
    logic [7:0] r_wdata;

    // Line data fetched from memory on a read miss.
    logic [7:0] r_fill;
    logic [7:0] r_cpu_rdata;
    logic [7:0] r_hit_count;
    logic [7:0] r_miss_count;

    // Single-cycle event strobes decoded from the current state.
    logic       w_accept;
    logic       w_check;
    logic       w_rd_ack;
    logic       w_rd_hit;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-dependent control outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_check      = 1'b0;
        w_rd_ack     = 1'b0;
        o_cpu_ready  = 1'b0;
        o_cpu_done   = 1'b0;
        o_cache_wren = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_cpu_ready = 1'b1;
                if (i_cpu_req) begin
                    w_accept     = 1'b1;
                    w_state_next = StLookup;
                end
            end
            StLookup: begin
                // Address is presented this cycle; hit flag arrives next cycle.
                w_state_next = StCheck;
            end
            StCheck: begin
                w_check = 1'b1;
                if (r_we) begin
                    w_state_next = StFill;
                end else if (i_cache_hit) begin
                    w_state_next = StResp;
                end else begin
                    w_state_next = StMemRd;
                end
            end
            StMemRd: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    w_rd_ack     = 1'b1;
                    w_state_next = StFill;
                end
            end
            StFill: begin
                o_cache_wren = 1'b1;
                w_state_next = r_we ? StMemWr : StResp;
            end
            StMemWr: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                if (i_mem_ack) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                o_cpu_done   = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_rd_hit = w_check && !r_we && i_cache_hit;

    // Latch the request on acceptance; ignored in every other state.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_we    <= 1'b0;
            r_addr  <= 5'd0;
            r_wdata <= 8'd0;
        end else if (w_accept) begin
            r_we    <= i_cpu_we;
            r_addr  <= i_cpu_addr;
            r_wdata <= i_cpu_wdata;
        end
    end

    // Capture memory read data for the cache fill.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_fill <= 8'd0;
        end else if (w_rd_ack) begin
            r_fill <= i_mem_rdata;
        end
    end

    // Read result register; only read transactions update it.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_cpu_rdata <= 8'd0;
        end else if (w_rd_hit) begin
            r_cpu_rdata <= i_cache_rdata;
        end else if (w_rd_ack) begin
            r_cpu_rdata <= i_mem_rdata;
        end
    end

    // Saturating hit/miss counters, stepped once per request in CHECK.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_hit_count  <= 8'd0;
            r_miss_count <= 8'd0;
        end else if (w_check) begin
            if (i_cache_hit) begin
                if (r_hit_count != CountMax) begin
                    r_hit_count <= r_hit_count + 8'd1;
                end
            end else begin
                if (r_miss_count != CountMax) begin
                    r_miss_count <= r_miss_count + 8'd1;
                end
            end
        end
    end

    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_cache_addr  = r_addr;
    assign o_mem_addr    = r_addr;
    // Writes allocate the CPU data; read misses fill with the memory data.
    assign o_cache_wdata = r_we ? r_wdata : r_fill;
    assign o_mem_wdata   = r_wdata;
    assign o_hit_count   = r_hit_count;
    assign o_miss_count  = r_miss_count;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: each request is expanded into its expected
// cycle-by-cycle plan (lookup, check, memory phase, fill, response) and the
// DUT outputs are compared against that plan on every cycle.
module tb_cache_miss_ctrl;

    logic       clk = 1'b0;
    logic       i_resetn;
    logic       i_cpu_req;
    logic       i_cpu_we;
    logic [4:0] i_cpu_addr;
    logic [7:0] i_cpu_wdata;
    logic       o_cpu_ready;
    logic       o_cpu_done;
    logic [7:0] o_cpu_rdata;
    logic [4:0] o_cache_addr;
    logic       o_cache_wren;
    logic [7:0] o_cache_wdata;
    logic       i_cache_hit;
    logic [7:0] i_cache_rdata;
    logic       o_mem_req;
    logic       o_mem_we;
    logic [4:0] o_mem_addr;
    logic [7:0] o_mem_wdata;
    logic       i_mem_ack;
    logic [7:0] i_mem_rdata;
    logic [7:0] o_hit_count;
    logic [7:0] o_miss_count;

    always #5 clk = ~clk;

    cache_miss_ctrl dut (
        .i_clock       (clk),
        .i_resetn      (i_resetn),
        .i_cpu_req     (i_cpu_req),
        .i_cpu_we      (i_cpu_we),
        .i_cpu_addr    (i_cpu_addr),
        .i_cpu_wdata   (i_cpu_wdata),
        .o_cpu_ready   (o_cpu_ready),
        .o_cpu_done    (o_cpu_done),
        .o_cpu_rdata   (o_cpu_rdata),
        .o_cache_addr  (o_cache_addr),
        .o_cache_wren  (o_cache_wren),
        .o_cache_wdata (o_cache_wdata),
        .i_cache_hit   (i_cache_hit),
        .i_cache_rdata (i_cache_rdata),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_hit_count   (o_hit_count),
        .o_miss_count  (o_miss_count)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;
    logic chk_en = 1'b0;

    // Expected control outputs for the current cycle.
    logic       e_ready, e_done, e_wren, e_mem_req, e_mem_we;
    logic [7:0] e_cache_wdata, e_mem_wdata;

    // Architectural model: latched address, read result, counters.
    logic [4:0] m_addr;
    logic [7:0] m_rdata;
    int         m_hits, m_misses;

    // Observations used by the literal checks.
    int         done_seen = 0;
    int         done_cyc = 0;
    int         memreq_seen = 0;
    int         wren_seen = 0;
    logic [7:0] last_fill = 8'd0;
    logic [7:0] last_mem_wdata = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc_n, act, req);
        end
    endtask

    // Per-cycle comparison against the plan and model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_ready", 32'(o_cpu_ready), 32'(e_ready));
            chk("cpu_done", 32'(o_cpu_done), 32'(e_done));
            chk("cache_wren", 32'(o_cache_wren), 32'(e_wren));
            chk("mem_req", 32'(o_mem_req), 32'(e_mem_req));
            chk("mem_we", 32'(o_mem_we), 32'(e_mem_we));
            chk("cache_addr", 32'(o_cache_addr), 32'(m_addr));
            chk("mem_addr", 32'(o_mem_addr), 32'(m_addr));
            chk("cpu_rdata", 32'(o_cpu_rdata), 32'(m_rdata));
            chk("hit_count", 32'(o_hit_count), 32'(m_hits));
            chk("miss_count", 32'(o_miss_count), 32'(m_misses));
            if (e_wren) chk("cache_wdata", 32'(o_cache_wdata), 32'(e_cache_wdata));
            if (e_mem_req && e_mem_we) chk("mem_wdata", 32'(o_mem_wdata), 32'(e_mem_wdata));
            if (o_cpu_done === 1'b1) begin
                done_seen++;
                done_cyc = cyc_n;
            end
            if (o_mem_req === 1'b1) begin
                memreq_seen++;
                if (o_mem_we === 1'b1) last_mem_wdata = o_mem_wdata;
            end
            if (o_cache_wren === 1'b1) begin
                wren_seen++;
                last_fill = o_cache_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic exp_base(input logic idle);
        e_ready       = idle;
        e_done        = 1'b0;
        e_wren        = 1'b0;
        e_mem_req     = 1'b0;
        e_mem_we      = 1'b0;
        e_cache_wdata = 8'd0;
        e_mem_wdata   = 8'd0;
    endtask

    // Random activity on every input the DUT must ignore in this cycle.
    task automatic noise(input logic allow_req);
        i_cpu_req     = allow_req ? 1'($urandom) : 1'b0;
        i_cpu_we      = 1'($urandom);
        i_cpu_addr    = 5'($urandom);
        i_cpu_wdata   = 8'($urandom);
        i_cache_hit   = 1'($urandom);
        i_cache_rdata = 8'($urandom);
        i_mem_ack     = 1'($urandom);
        i_mem_rdata   = 8'($urandom);
    endtask

    task automatic model_reset();
        m_addr   = 5'd0;
        m_rdata  = 8'd0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_reset();
        exp_base(1'b1);
        noise(1'b1);
        i_resetn = 1'b0;
        tick();
        i_resetn = 1'b1;
        model_reset();
    endtask

    // One complete request: gap idle cycles, acceptance, then its full plan.
    task automatic do_request(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                              input logic hit, input logic [7:0] crd, input int lat,
                              input logic [7:0] md, input int gap, output int acc);
        for (int i = 0; i < gap; i++) begin
            exp_base(1'b1);
            noise(1'b0);
            tick();
        end
        exp_base(1'b1);
        noise(1'b0);
        i_cpu_req   = 1'b1;
        i_cpu_we    = we;
        i_cpu_addr  = addr;
        i_cpu_wdata = wd;
        acc = cyc_n;
        tick();
        m_addr = addr;
        exp_base(1'b0);
        noise(1'b1);
        tick();
        exp_base(1'b0);
        noise(1'b1);
        i_cache_hit   = hit;
        i_cache_rdata = crd;
        tick();
        if (hit) m_hits = sat_inc(m_hits);
        else m_misses = sat_inc(m_misses);
        if (!we && hit) begin
            m_rdata = crd;
        end else begin
            if (!we) begin
                for (int j = 0; j < lat; j++) begin
                    exp_base(1'b0);
                    e_mem_req = 1'b1;
                    noise(1'b1);
                    i_mem_ack = (j == lat - 1);
                    if (j == lat - 1) i_mem_rdata = md;
                    tick();
                end
                m_rdata = md;
            end
            exp_base(1'b0);
            e_wren        = 1'b1;
            e_cache_wdata = we ? wd : md;
            noise(1'b1);
            tick();
            if (we) begin
                for (int j = 0; j < lat; j++) begin
                    exp_base(1'b0);
                    e_mem_req   = 1'b1;
                    e_mem_we    = 1'b1;
                    e_mem_wdata = wd;
                    noise(1'b1);
                    i_mem_ack = (j == lat - 1);
                    tick();
                end
            end
        end
        exp_base(1'b0);
        e_done = 1'b1;
        noise(1'b1);
        tick();
    endtask

    initial begin
        int acc;
        int d0, m0, w0;
        exp_base(1'b1);
        noise(1'b0);
        model_reset();
        i_resetn = 1'b0;
        tick();
        tick();
        i_resetn = 1'b1;
        chk_en = 1'b1;

        // Reset state, hand-computed.
        chk("rst_ready", 32'(o_cpu_ready), 32'd1);
        chk("rst_done", 32'(o_cpu_done), 32'd0);
        chk("rst_rdata", 32'(o_cpu_rdata), 32'd0);
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_hits", 32'(o_hit_count), 32'd0);
        chk("rst_misses", 32'(o_miss_count), 32'd0);

        // Cold read miss, ack in the second memory cycle.
        w0 = wren_seen;
        do_request(1'b0, 5'b01_011, 8'h00, 1'b0, 8'h00, 2, 8'hA5, 0, acc);
        chk("miss_latency", 32'(done_cyc - acc), 32'd6);
        chk("miss_fill_cycles", 32'(wren_seen - w0), 32'd1);
        chk("miss_fill_data", 32'(last_fill), 32'hA5);
        chk("miss_rdata", 32'(o_cpu_rdata), 32'hA5);
        chk("miss_count1", 32'(o_miss_count), 32'd1);

        // Same address again, now a hit.
        m0 = memreq_seen;
        do_request(1'b0, 5'b01_011, 8'h00, 1'b1, 8'hA5, 1, 8'h00, 1, acc);
        chk("hit_latency", 32'(done_cyc - acc), 32'd3);
        chk("hit_no_mem", 32'(memreq_seen - m0), 32'd0);
        chk("hit_count1", 32'(o_hit_count), 32'd1);

        // Write miss with write-allocate and write-through.
        m0 = memreq_seen;
        d0 = done_seen;
        do_request(1'b1, 5'b10_000, 8'h3C, 1'b0, 8'h00, 2, 8'h00, 0, acc);
        chk("wr_latency", 32'(done_cyc - acc), 32'd6);
        chk("wr_fill_data", 32'(last_fill), 32'h3C);
        chk("wr_mem_cycles", 32'(memreq_seen - m0), 32'd2);
        chk("wr_mem_wdata", 32'(last_mem_wdata), 32'h3C);
        chk("wr_done_once", 32'(done_seen - d0), 32'd1);
        chk("wr_rdata_kept", 32'(o_cpu_rdata), 32'hA5);

        // Reset during the memory read phase aborts the request.
        exp_base(1'b1);
        noise(1'b0);
        i_cpu_req  = 1'b1;
        i_cpu_we   = 1'b0;
        i_cpu_addr = 5'b00_110;
        tick();
        m_addr = 5'b00_110;
        exp_base(1'b0);
        noise(1'b1);
        tick();
        exp_base(1'b0);
        noise(1'b1);
        i_cache_hit = 1'b0;
        tick();
        m_misses = sat_inc(m_misses);
        for (int j = 0; j < 2; j++) begin
            exp_base(1'b0);
            e_mem_req = 1'b1;
            noise(1'b1);
            i_mem_ack = 1'b0;
            if (j == 1) i_resetn = 1'b0;
            tick();
        end
        i_resetn = 1'b1;
        model_reset();
        d0 = done_seen;
        m0 = memreq_seen;
        for (int j = 0; j < 4; j++) begin
            exp_base(1'b1);
            noise(1'b0);
            i_mem_ack = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);
        chk("abort_no_mem_req", 32'(memreq_seen - m0), 32'd0);
        chk("abort_ready", 32'(o_cpu_ready), 32'd1);
        chk("abort_misses", 32'(o_miss_count), 32'd0);

        // 256 hits from reset saturate at 255.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            do_request(1'b0, 5'($urandom), 8'($urandom), 1'b1, 8'($urandom), 1, 8'h00,
                       int'($urandom_range(0, 1)), acc);
        end
        chk("hit_saturate", 32'(o_hit_count), 32'd255);
        chk("hit_sat_misses", 32'(o_miss_count), 32'd0);

        // Randomized mix of reads/writes, hits/misses and memory latencies.
        do_reset();
        d0 = done_seen;
        for (int k = 0; k < 300; k++) begin
            do_request(1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                       int'($urandom_range(1, 4)), 8'($urandom), int'($urandom_range(0, 3)), acc);
        end
        chk("rand_done_count", 32'(done_seen - d0), 32'd300);

        exp_base(1'b1);
        noise(1'b0);
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
